// File: rtl/mem_wb_skid_pkg.sv
// Shared constants and types for the MEM->WB skid stage.
// Write-enable/reset levels, NOP/zero fill values, occupancy encoding, FSM states.
// No ports; imported by the stage, its payload register and the interface users.
package mem_wb_skid_pkg;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;

    // The NOP register address and the zero word are all-zeros at any width,
    // so they are kept as fill bits and replicated to the parametrised width.
    localparam logic NopAddrBit = 1'b0;
    localparam logic ZeroBit    = 1'b0;

    localparam logic [1:0] OccEmpty = 2'd0;
    localparam logic [1:0] OccOne   = 2'd1;
    localparam logic [1:0] OccFull  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(state_t s);
        logic [1:0] o;
        o = OccEmpty;
        case (s)
            ST_ONE:  o = OccOne;
            ST_FULL: o = OccFull;
            default: o = OccEmpty;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_wb_skid_if.sv
// MEM->WB handshake and payload bundle, LANES records per beat, lane 0 in the LSBs.
// slave: the skid stage's view (accepts from MEM, presents to WB).
// master: the environment's view (drives MEM side and WB ready, observes outputs).
interface mem_wb_skid_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*ADDR_W-1:0]   mem_wd;
    logic [LANES-1:0]          mem_wreg;
    logic [LANES*DATA_W-1:0]   mem_wdata;
    logic [LANES*DATA_W-1:0]   mem_hi;
    logic [LANES*DATA_W-1:0]   mem_lo;
    logic [LANES-1:0]          mem_whilo;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ADDR_W-1:0]   wb_wd;
    logic [LANES-1:0]          wb_wreg;
    logic [LANES*DATA_W-1:0]   wb_wdata;
    logic [LANES*DATA_W-1:0]   wb_hi;
    logic [LANES*DATA_W-1:0]   wb_lo;
    logic [LANES-1:0]          wb_whilo;
    logic [1:0]                occupancy;

    modport slave (
        input  flush, in_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, out_ready,
        output in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, occupancy
    );

    modport master (
        output flush, in_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, out_ready,
        input  in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, occupancy
    );
endinterface

// File: rtl/mem_wb_skid_wb_rec_reg.sv
// Single write-back record register (all lanes) with load enable and synchronous clear.
// Ports: clk, clr (sync, wins over load), load, d_* in, q_* out.
// Clear value is the NOP address, disabled enables and zero data.
module wb_rec_reg
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    load,
    input  logic [LANES*ADDR_W-1:0] d_wd,
    input  logic [LANES-1:0]        d_wreg,
    input  logic [LANES*DATA_W-1:0] d_wdata,
    input  logic [LANES*DATA_W-1:0] d_hi,
    input  logic [LANES*DATA_W-1:0] d_lo,
    input  logic [LANES-1:0]        d_whilo,
    output logic [LANES*ADDR_W-1:0] q_wd,
    output logic [LANES-1:0]        q_wreg,
    output logic [LANES*DATA_W-1:0] q_wdata,
    output logic [LANES*DATA_W-1:0] q_hi,
    output logic [LANES*DATA_W-1:0] q_lo,
    output logic [LANES-1:0]        q_whilo
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q_wd    <= {(LANES*ADDR_W){NopAddrBit}};
            q_wreg  <= {LANES{WriteDisable}};
            q_wdata <= {(LANES*DATA_W){ZeroBit}};
            q_hi    <= {(LANES*DATA_W){ZeroBit}};
            q_lo    <= {(LANES*DATA_W){ZeroBit}};
            q_whilo <= {LANES{WriteDisable}};
        end else if (load == WriteEnable) begin
            q_wd    <= d_wd;
            q_wreg  <= d_wreg;
            q_wdata <= d_wdata;
            q_hi    <= d_hi;
            q_lo    <= d_lo;
            q_whilo <= d_whilo;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush and per-lane enable gating.
// Ports: clk, rst (sync, active-high), bus (slave modport: MEM offer, WB head, occupancy).
// Latency 1 cycle; in_ready registered from next state, so no out_ready->in_ready path.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_skid_if.slave   bus
);

    localparam int AW = LANES*ADDR_W;
    localparam int DW = LANES*DATA_W;

    state_t     state_q;
    state_t     state_nxt;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [1:0] occ_q;

    logic in_xfer;
    logic out_xfer;
    logic head_load;
    logic head_from_skid;
    logic skid_load;

    logic [AW-1:0]    head_wd,    skid_wd,    head_d_wd;
    logic [LANES-1:0] head_wreg,  skid_wreg,  head_d_wreg;
    logic [DW-1:0]    head_wdata, skid_wdata, head_d_wdata;
    logic [DW-1:0]    head_hi,    skid_hi,    head_d_hi;
    logic [DW-1:0]    head_lo,    skid_lo,    head_d_lo;
    logic [LANES-1:0] head_whilo, skid_whilo, head_d_whilo;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_nxt = ST_FULL;
                else if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (out_xfer) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything, including a beat WB is taking this cycle
        // (WB still acts on that one; it simply is not kept here).
        if (bus.flush) state_nxt = ST_EMPTY;
    end

    // Payload moves are suppressed on flush: the head keeps its last contents
    // so only the enables (gated below) change when the stage empties.
    always_comb begin
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = (state_q == ST_FULL);
        if (!bus.flush) begin
            case (state_q)
                ST_EMPTY: head_load = in_xfer;
                ST_ONE: begin
                    head_load = in_xfer & out_xfer;
                    skid_load = in_xfer & ~out_xfer;
                end
                ST_FULL:  head_load = out_xfer;
                default: begin
                    head_load = 1'b0;
                    skid_load = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if (head_from_skid) begin
            head_d_wd    = skid_wd;
            head_d_wreg  = skid_wreg;
            head_d_wdata = skid_wdata;
            head_d_hi    = skid_hi;
            head_d_lo    = skid_lo;
            head_d_whilo = skid_whilo;
        end else begin
            head_d_wd    = bus.mem_wd;
            head_d_wreg  = bus.mem_wreg;
            head_d_wdata = bus.mem_wdata;
            head_d_hi    = bus.mem_hi;
            head_d_lo    = bus.mem_lo;
            head_d_whilo = bus.mem_whilo;
        end
    end

    // Control FSM; all handshake outputs are decoded from next state and registered.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= OccEmpty;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= (state_nxt != ST_FULL);
            out_valid_q <= (state_nxt != ST_EMPTY);
            occ_q       <= occ_of(state_nxt);
        end
    end

    wb_rec_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_head (
        .clk     (clk),
        .clr     (rst),
        .load    (head_load),
        .d_wd    (head_d_wd),
        .d_wreg  (head_d_wreg),
        .d_wdata (head_d_wdata),
        .d_hi    (head_d_hi),
        .d_lo    (head_d_lo),
        .d_whilo (head_d_whilo),
        .q_wd    (head_wd),
        .q_wreg  (head_wreg),
        .q_wdata (head_wdata),
        .q_hi    (head_hi),
        .q_lo    (head_lo),
        .q_whilo (head_whilo)
    );

    wb_rec_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_skid (
        .clk     (clk),
        .clr     (rst),
        .load    (skid_load),
        .d_wd    (bus.mem_wd),
        .d_wreg  (bus.mem_wreg),
        .d_wdata (bus.mem_wdata),
        .d_hi    (bus.mem_hi),
        .d_lo    (bus.mem_lo),
        .d_whilo (bus.mem_whilo),
        .q_wd    (skid_wd),
        .q_wreg  (skid_wreg),
        .q_wdata (skid_wdata),
        .q_hi    (skid_hi),
        .q_lo    (skid_lo),
        .q_whilo (skid_whilo)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.occupancy = occ_q;
    assign bus.wb_wd     = head_wd;
    assign bus.wb_wdata  = head_wdata;
    assign bus.wb_hi     = head_hi;
    assign bus.wb_lo     = head_lo;
    // No register or HI/LO write may leave an empty or flushed stage.
    assign bus.wb_wreg   = head_wreg  & {LANES{out_valid_q}};
    assign bus.wb_whilo  = head_whilo & {LANES{out_valid_q}};

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid with LANES=2: directed steps followed by random traffic,
// every cycle compared against a queue-based model of the stage.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_mem_wb_skid;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LANES  = 2;

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
        logic [LANES*DATA_W-1:0] hi;
        logic [LANES*DATA_W-1:0] lo;
        logic [LANES-1:0]        whilo;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  flush;
    logic  in_valid;
    logic  out_ready;
    beat_t cur;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stage is a FIFO of at most two beats; what the
    // data outputs show is the most recent beat that sat at the front.
    beat_t q[$];
    beat_t last = '0;
    bit    m_in_ready = 1'b1;
    bit    in_x;
    bit    out_x;

    mem_wb_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    assign bus.flush     = flush;
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
    assign bus.mem_wd    = cur.wd;
    assign bus.mem_wreg  = cur.wreg;
    assign bus.mem_wdata = cur.wdata;
    assign bus.mem_hi    = cur.hi;
    assign bus.mem_lo    = cur.lo;
    assign bus.mem_whilo = cur.whilo;

    mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            last       = '0;
            m_in_ready = 1'b1;
        end else begin
            in_x  = in_valid && m_in_ready;
            out_x = (q.size() > 0) && out_ready;
            if (q.size() > 0) last = q[0];
            if (out_x) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_x) q.push_back(cur);
            if (q.size() > 0) last = q[0];
            m_in_ready = (q.size() < 2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ov;
        ov = (q.size() > 0);
        chk("in_ready",  64'(bus.in_ready),  64'(m_in_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(ov));
        chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
        chk("wb_wd",     64'(bus.wb_wd),     64'(last.wd));
        chk("wb_wdata",  64'(bus.wb_wdata),  64'(last.wdata));
        chk("wb_hi",     64'(bus.wb_hi),     64'(last.hi));
        chk("wb_lo",     64'(bus.wb_lo),     64'(last.lo));
        chk("wb_wreg",   64'(bus.wb_wreg),   ov ? 64'(last.wreg)  : 64'd0);
        chk("wb_whilo",  64'(bus.wb_whilo),  ov ? 64'(last.whilo) : 64'd0);
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        b.wd    = 10'($urandom);
        b.wreg  = 2'($urandom);
        b.wdata = {$urandom, $urandom};
        b.hi    = {$urandom, $urandom};
        b.lo    = {$urandom, $urandom};
        b.whilo = 2'($urandom);
        return b;
    endfunction

    beat_t a, b, c;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cur       = rnd_beat();

        // Reset held for two cycles while MEM offers a beat.
        repeat (2) step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_wb_wd",     64'(bus.wb_wd),     64'd0);

        // First beat after release appears one cycle after acceptance.
        rst = 1'b0;
        cur = rnd_beat();
        step();
        chk("first_valid", 64'(bus.out_valid), 64'd1);
        chk("first_wd",    64'(bus.wb_wd),     64'(cur.wd));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();

        // Streaming with WB always ready.
        for (int i = 1; i <= 8; i++) begin
            cur = rnd_beat();
            cur.wd[4:0]     = 5'(i);
            cur.wdata[31:0] = 32'h100 + 32'(i);
            in_valid = 1'b1;
            step();
            chk("stream_wd",    64'(bus.wb_wd[4:0]),     64'(i));
            chk("stream_wdata", 64'(bus.wb_wdata[31:0]), 64'h100 + 64'(i));
            chk("stream_occ",   64'(bus.occupancy),      64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(bus.out_valid), 64'd0);

        // Back-pressure: A and B fill the stage, then drain in order.
        out_ready = 1'b0;
        a = rnd_beat();
        b = rnd_beat();
        cur = a; in_valid = 1'b1;
        step();
        cur = b;
        step();
        chk("bp_occ",      64'(bus.occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
        step();
        chk("bp_hold_a",   64'(bus.wb_wd),     64'(a.wd));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_then_b",   64'(bus.wb_wd),     64'(b.wd));
        chk("bp_ready_up", 64'(bus.in_ready),  64'd1);
        step();
        chk("bp_empty",    64'(bus.out_valid), 64'd0);

        // Flush from FULL with beat C offered in the flush cycle.
        out_ready = 1'b0;
        cur = rnd_beat(); in_valid = 1'b1;
        step();
        cur = rnd_beat();
        step();
        c = rnd_beat();
        c.wreg  = 2'b11;
        c.whilo = 2'b11;
        cur = c; flush = 1'b1;
        step();
        chk("fl_valid",    64'(bus.out_valid), 64'd0);
        chk("fl_wreg",     64'(bus.wb_wreg),   64'd0);
        chk("fl_whilo",    64'(bus.wb_whilo),  64'd0);
        chk("fl_in_ready", 64'(bus.in_ready),  64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl_c_absent", 64'(bus.out_valid), 64'd0);
        end

        // Two lanes carried together; enables drop once the beat leaves.
        cur = '0;
        cur.wd[4:0]     = 5'd3;
        cur.wreg        = 2'b01;
        cur.whilo       = 2'b10;
        cur.hi[63:32]   = 32'hDEAD;
        cur.lo[63:32]   = 32'hBEEF;
        in_valid = 1'b1;
        step();
        chk("ml_wd",    64'(bus.wb_wd),        64'd3);
        chk("ml_wreg",  64'(bus.wb_wreg),      64'd1);
        chk("ml_whilo", 64'(bus.wb_whilo),     64'd2);
        chk("ml_hi1",   64'(bus.wb_hi[63:32]), 64'hDEAD);
        chk("ml_lo1",   64'(bus.wb_lo[63:32]), 64'hBEEF);
        in_valid = 1'b0;
        step();
        chk("ml_wreg_off",  64'(bus.wb_wreg),      64'd0);
        chk("ml_whilo_off", 64'(bus.wb_whilo),     64'd0);
        chk("ml_hi_kept",   64'(bus.wb_hi[63:32]), 64'hDEAD);

        // Reset with beats buffered discards them.
        out_ready = 1'b0;
        cur = rnd_beat(); in_valid = 1'b1;
        step();
        cur = rnd_beat();
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_occ",   64'(bus.occupancy), 64'd0);
        rst = 1'b0;
        step();

        // Random traffic; payload held while an offer is stalled.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = 1'($urandom);
            if (!(in_valid && !m_in_ready)) begin
                in_valid = 1'($urandom);
                cur      = rnd_beat();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM→WB pipeline register with valid/ready handshake, a 2-entry skid buffer, flush, and per-lane write-enable gating. It sits between the memory-access stage and the register-file/HI-LO write-back port, carrying `LANES` independent write-back records per beat. It lets write-back back-pressure MEM without a combinational ready path, and it guarantees that no register or HI/LO write escapes while the stage is empty or flushed.

## Interface
- `DATA_W`, default 32: width of `wdata`, `hi`, `lo` per lane.
- `ADDR_W`, default 5: register address width per lane.
- `LANES`, default 1: write-back records per beat; all per-lane ports are packed, lane 0 in the LSBs.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered beats and any beat offered in the same cycle.
- `in_valid` in 1: MEM offers a beat.
- `in_ready` out 1: stage accepts a beat; registered.
- `mem_wd` in `LANES*ADDR_W`: destination register address per lane.
- `mem_wreg` in `LANES`: register write enable per lane.
- `mem_wdata` in `LANES*DATA_W`: register write data per lane.
- `mem_hi`, `mem_lo` in `LANES*DATA_W`: HI/LO write data per lane.
- `mem_whilo` in `LANES`: HI/LO write enable per lane.
- `out_valid` out 1: head beat presented to WB.
- `out_ready` in 1: WB consumes the head beat.
- `wb_wd`, `wb_wreg`, `wb_wdata`, `wb_hi`, `wb_lo`, `wb_whilo` out: per-lane head-beat fields, same widths as the matching inputs.
- `occupancy` out 2: number of buffered beats, 0–2.

## Operation
- Transfers: an input transfer happens when `in_valid & in_ready`. An output transfer happens when `out_valid & out_ready`.
- States:
  - EMPTY: 0 beats.
  - ONE: head only.
  - FULL: head plus skid.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in, no out → FULL.
  - ONE + out, no in → EMPTY.
  - ONE + in + out → ONE, with head replaced by the input.
  - FULL + out → ONE, with skid moved to head.
  - FULL never accepts input.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL. It is computed from next state and registered.
- `out_valid` = 1 in ONE and FULL.
- `occupancy` = 0, 1 or 2 for EMPTY, ONE and FULL.
- Enable gating: `wb_wreg` and `wb_whilo` are forced to 0 whenever `out_valid` = 0. Data fields keep their last values.
- Flush:
  - Next state is EMPTY regardless of in/out activity.
  - The offered input is dropped.
  - An output transfer in the flush cycle still counts as consumed. WB acts on it.
  - `in_ready` is 1 in the following cycle.
- Lanes: lanes are independent payload only. Handshake and state are shared by the whole beat.
- FIFO order: beats leave in arrival order. No reordering, no merging.

## Timing
- Latency: 1 cycle from input transfer to `out_valid` when EMPTY.
- Throughput: 1 beat/cycle sustained when `out_ready` is held 1.
- Back-pressure: `in_ready` falls 1 cycle after the transfer that filled the skid entry. There is no combinational path from `out_ready` to `in_ready`.
- Reset (`rst` = 1 at an edge), taking priority over `flush`:
  - State → EMPTY.
  - `in_ready` = 1, `out_valid` = 0, `occupancy` = 0.
  - All `wb_*` fields = 0, including `wb_wd` = 0, which is the NOP register address.
- Reset mid-operation: buffered beats are discarded with no write-back.
- Input held with `in_ready` = 0: MEM must keep payload stable while `in_valid` = 1. The block does not check this.

## Structure
- Shared defines package holds:
  - Write-enable and reset-level constants (`WriteEnable`/`WriteDisable`, `RstEnable`).
  - The NOP register address and zero word.
  - An occupancy encoding constant set for EMPTY, ONE and FULL.
- One sub-module, `wb_rec_reg`: a single-entry payload register with load enable and synchronous clear, instantiated twice (head, skid).
- The control FSM stays in `mem_wb_skid`.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `in_ready` = 1, all `wb_*` = 0, `occupancy` = 0. On release, the first beat appears 1 cycle after acceptance.
- Streaming: 8 beats with `mem_wd` = 1..8 and `mem_wdata` = 0x100+i, `out_ready` = 1 → `wb_wd` 1..8 on consecutive cycles, 1-cycle latency, `occupancy` stays 1.
- Back-pressure: `out_ready` = 0 while sending beats A and B → `occupancy` = 2 and `in_ready` = 0 after B. Raising `out_ready` → A then B in order, and `in_ready` returns to 1.
- Flush: FULL with beats A and B, assert `flush` with `in_valid` = 1 (beat C) → next cycle `out_valid` = 0, `wb_wreg` = `wb_whilo` = 0, C never appears.
- Multi-lane: `LANES` = 2, lane0 `wd` = 3 `wreg` = 1, lane1 `whilo` = 1 `hi` = 0xDEAD `lo` = 0xBEEF → both lanes present together, and their enables drop to 0 once the beat is consumed with no new input.
